// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encoding is fixed so the FSM stays compatible with older flows.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // Step counter width: $clog2(n), but never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; one slice of the bit-serial adder's carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: LSB-first, BITS_PER_CYCLE bits per clock, one-cycle done pulse.
// Optional subtract port `sub` when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_seq
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned BPC      = BITS_PER_CYCLE;
   localparam int unsigned N        = WIDTH / BPC;
   localparam int unsigned CW       = cnt_width(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   if ((WIDTH < 2) || (BPC == 0) || ((WIDTH % BPC) != 0)) begin : g_param_check
      $error("serial_adder_seq: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   // Operand conditioning at start time.
   logic [WIDTH-1:0] b_load;
   logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load   = sub ? ~b : b;
   assign cin_load = sub ? ~cin : cin;
`else
   assign b_load   = b;
   assign cin_load = cin;
`endif

   // Combinational carry chain across the slices used this cycle.
   logic [BPC:0]   chain;
   logic [BPC-1:0] sum_bits;

   assign chain[0] = carry_q;

   for (genvar i = 0; i < BPC; i++) begin : g_slice
      full_adder u_fa (
         .a    (a_q[i]),
         .b    (b_q[i]),
         .cin  (chain[i]),
         .sum  (sum_bits[i]),
         .cout (chain[i+1])
      );
   end

   // The A register doubles as the sum accumulator: consumed LSBs shift out while
   // fresh sum bits enter from the MSB side, so after N steps it holds the full sum.
   logic [WIDTH-1:0] a_next;

   if (BPC == WIDTH) begin : g_acc_full
      assign a_next = sum_bits;
   end else begin : g_acc_shift
      assign a_next = {sum_bits, a_q[WIDTH-1:BPC]};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               a_d      = a;
               b_d      = b_load;
               carry_d  = cin_load;
               cnt_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            a_d     = a_next;
            b_d     = b_q >> BPC;
            carry_d = chain[BPC];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               result_d = a_next;
               cout_d   = chain[BPC];
               // Carry into the MSB vs. carry out of it flags signed overflow.
               ovf_d    = chain[BPC] ^ chain[BPC-1];
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq with BITS_PER_CYCLE=1 and =4 instances side by side.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       cin_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub_in = 1'b0;
`endif
   logic       start1 = 1'b0;
   logic       start4 = 1'b0;

   logic       busy1, done1, cout1, ovf1;
   logic [7:0] res1;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] res4;

   logic       sel4 = 1'b0;
   logic       busy_s, done_s, cout_s, ovf_s;
   logic [7:0] res_s;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start1),
      .a        (a_in),
      .b        (b_in),
      .cin      (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub      (sub_in),
`endif
      .busy     (busy1),
      .done     (done1),
      .result   (res1),
      .cout     (cout1),
      .overflow (ovf1)
   );

   serial_adder_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start4),
      .a        (a_in),
      .b        (b_in),
      .cin      (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub      (sub_in),
`endif
      .busy     (busy4),
      .done     (done4),
      .result   (res4),
      .cout     (cout4),
      .overflow (ovf4)
   );

   assign busy_s = sel4 ? busy4 : busy1;
   assign done_s = sel4 ? done4 : done1;
   assign res_s  = sel4 ? res4  : res1;
   assign cout_s = sel4 ? cout4 : cout1;
   assign ovf_s  = sel4 ? ovf4  : ovf1;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Presents operands with start for one clock; returns in RUN cycle 1.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic ci);
      a_in   = a;
      b_in   = b;
      cin_in = ci;
      if (sel4) start4 = 1'b1;
      else      start1 = 1'b1;
      cycle();
      start1 = 1'b0;
      start4 = 1'b0;
   endtask

   // Walks the remaining RUN cycles and checks the DONE cycle; optionally pokes a
   // second start (different operands) during RUN cycle 3.
   task automatic finish_op(input string tag, input logic [7:0] er, input logic ec,
                            input logic eo, input bit inject);
      int n;
      n = sel4 ? 2 : 8;
      check_eq({tag, ".busy0"}, 8'(busy_s), 8'd1);
      check_eq({tag, ".clr"}, res_s, 8'h00);
      for (int i = 1; i < n; i++) begin
         if (inject && (i == 3)) begin
            a_in   = 8'hAA;
            b_in   = 8'h55;
            start1 = 1'b1;
         end
         cycle();
         start1 = 1'b0;
         check_eq($sformatf("%s.busy%0d", tag, i), 8'(busy_s), 8'd1);
         check_eq($sformatf("%s.nodone%0d", tag, i), 8'(done_s), 8'd0);
      end
      cycle();
      check_eq({tag, ".done"}, 8'(done_s), 8'd1);
      check_eq({tag, ".idle"}, 8'(busy_s), 8'd0);
      check_eq({tag, ".res"}, res_s, er);
      check_eq({tag, ".cout"}, 8'(cout_s), 8'(ec));
      check_eq({tag, ".ovf"}, 8'(ovf_s), 8'(eo));
   endtask

   task automatic check_hold(input string tag, input logic [7:0] er);
      cycle();
      check_eq({tag, ".pulse"}, 8'(done_s), 8'd0);
      check_eq({tag, ".hold"}, res_s, er);
   endtask

   initial begin
      #12;
      check_eq("rst.busy1", 8'(busy1), 8'd0);
      check_eq("rst.done1", 8'(done1), 8'd0);
      check_eq("rst.res1", res1, 8'h00);
      check_eq("rst.cout1", 8'(cout1), 8'd0);
      check_eq("rst.ovf1", 8'(ovf1), 8'd0);
      check_eq("rst.busy4", 8'(busy4), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // BPC=1 basic add, wrap-around, carry-in overflow (back-to-back from DONE).
      sel4 = 1'b0;
      launch(8'h5A, 8'h3C, 1'b0);
      finish_op("t1", 8'h96, 1'b0, 1'b1, 1'b0);
      check_hold("t1", 8'h96);
      launch(8'hFF, 8'h01, 1'b0);
      finish_op("t2a", 8'h00, 1'b1, 1'b0, 1'b0);
      launch(8'h7F, 8'h00, 1'b1);
      finish_op("t2b", 8'h80, 1'b0, 1'b1, 1'b0);
      check_hold("t2b", 8'h80);

      // BPC=4: two RUN cycles per op.
      sel4 = 1'b1;
      launch(8'hC8, 8'h64, 1'b0);
      finish_op("t3a", 8'h2C, 1'b1, 1'b0, 1'b0);
      launch(8'h7F, 8'h01, 1'b0);
      finish_op("t3b", 8'h80, 1'b0, 1'b1, 1'b0);
      check_hold("t3b", 8'h80);

      // Start during RUN is ignored; start in DONE is accepted immediately.
      sel4 = 1'b0;
      launch(8'h12, 8'h34, 1'b1);
      finish_op("t4a", 8'h47, 1'b0, 1'b0, 1'b1);
      launch(8'h80, 8'h80, 1'b0);
      finish_op("t4b", 8'h00, 1'b1, 1'b1, 1'b0);
      cycle();

      // Asynchronous reset mid-RUN, then a clean operation.
      launch(8'h0F, 8'hF0, 1'b1);
      repeat (3) cycle();
      check_eq("t5.pre", 8'(busy1), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5.busy", 8'(busy1), 8'd0);
      check_eq("t5.done", 8'(done1), 8'd0);
      check_eq("t5.res", res1, 8'h00);
      check_eq("t5.cout", 8'(cout1), 8'd0);
      check_eq("t5.ovf", 8'(ovf1), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check_eq("t5.stay", 8'(busy1), 8'd0);
      launch(8'h33, 8'h44, 1'b0);
      finish_op("t5b", 8'h77, 1'b0, 1'b0, 1'b0);
      cycle();

`ifdef SERIAL_ADDER_SUB_EN
      sub_in = 1'b1;
      launch(8'h10, 8'h20, 1'b0);
      finish_op("t6a", 8'hF0, 1'b0, 1'b0, 1'b0);
      launch(8'h20, 8'h10, 1'b0);
      finish_op("t6b", 8'h10, 1'b1, 1'b0, 1'b0);
      sel4 = 1'b1;
      launch(8'h10, 8'h20, 1'b0);
      finish_op("t6c", 8'hF0, 1'b0, 1'b0, 1'b0);
      sub_in = 1'b0;
      cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
